// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM states, op codes and
// default datapath widths.
package mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    // Wait counter width covers the legal WAIT_STATES range 0..15.
    localparam int unsigned CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Only meaningful when exactly one of read/write is high.
    function automatic op_t decode_op(input logic write);
        return write ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Memory bus between the CPU datapath (master) and the memory responder (slave).
interface memory_responder_if import mem_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] mar_addr;
    logic [DATA_WIDTH-1:0] mdr_data;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] mdatain;
    logic                  mem_busy;
    logic                  mem_done;
    logic                  mem_error;

    modport master (
        output mar_addr, mdr_data, read, write,
        input  mdatain, mem_busy, mem_done, mem_error
    );

    modport slave (
        input  mar_addr, mdr_data, read, write,
        output mdatain, mem_busy, mem_done, mem_error
    );

endinterface

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, read-before-write, registered output, no reset.
module ram_sp import mem_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_dout;

    // Array write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        r_dout <= r_mem[addr];
    end

    assign dout = r_dout;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: latches a request, waits WAIT_STATES cycles, performs
// one RAM access and completes with a 4-phase request/done handshake.
module memory_responder import mem_pkg::*; #(
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               clr,
    memory_responder_if.slave  bus
);

    localparam bit                   LP_HAS_WAIT  = (WAIT_STATES != 0);
    localparam logic [CNT_WIDTH-1:0] LP_WAIT_LOAD =
        LP_HAS_WAIT ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

    state_t                r_state,   w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt,     w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,    w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data,    w_data_nxt;
    op_t                   r_op,      w_op_nxt;
    logic [DATA_WIDTH-1:0] r_mdatain, w_mdatain_nxt;
    logic                  r_busy,    w_busy_nxt;
    logic                  r_done,    w_done_nxt;
    logic                  r_error,   w_error_nxt;

    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    // RAM read port runs one cycle ahead: in IDLE it tracks the live address so
    // the word is already in dout when ACCESS is entered, even with no wait states.
    ram_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .din  (r_data),
        .dout (w_ram_dout)
    );

    // State, latches and registered outputs; RAM contents are not touched by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_op      <= OP_READ;
            r_mdatain <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_op      <= w_op_nxt;
            r_mdatain <= w_mdatain_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
        end
    end

    // Next-state, handshake and RAM control decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_op_nxt      = r_op;
        w_mdatain_nxt = r_mdatain;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_error_nxt   = 1'b0;
        w_ram_we      = 1'b0;
        w_ram_addr    = r_addr;

        unique case (r_state)
            IDLE: begin
                w_ram_addr = bus.mar_addr;
                if (bus.read ^ bus.write) begin
                    w_addr_nxt  = bus.mar_addr;
                    w_data_nxt  = bus.mdr_data;
                    w_op_nxt    = decode_op(bus.write);
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = LP_WAIT_LOAD;
                    w_state_nxt = LP_HAS_WAIT ? WAIT : ACCESS;
                end else if (bus.read && bus.write) begin
                    w_error_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACCESS: begin
                if (r_op == OP_WRITE) begin
                    w_ram_we = 1'b1;
                end else begin
                    w_mdatain_nxt = w_ram_dout;
                end
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                // Holding a request here never restarts an access.
                if (!bus.read && !bus.write) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mdatain   = r_mdatain;
    assign bus.mem_busy  = r_busy;
    assign bus.mem_done  = r_done;
    assign bus.mem_error = r_error;

endmodule
